miriscv_irq_ctrl: RTL and testbench
===================================

Name: miriscv_irq_ctrl

Overview:
- Parametrised interrupt controller between external request lines and the miriscv core's trap logic.
- Latches and masks up to N_IRQ sources, each configurable as edge or level.
- Arbitrates one winner, presents it to the core with an mcause value, waits for trap entry and mret, then returns a one-cycle completion pulse to the winning source.
- Successor to the fixed 32-line int_req/int_fin interface of miriscv_top.

Parameters:
- N_IRQ, 32, number of interrupt lines (1..32).
- EDGE_MASK, '0 (N_IRQ bits), bit i = 1 makes line i edge-triggered; 0 makes it level-triggered.
- CAUSE_BASE, 16, mcause code of line 0; line i reports CAUSE_BASE + i.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_n_i  in  1  reset, asynchronous assert, active-low.
- int_req_i  in  N_IRQ  request lines; synchronous to clk_i.
- int_fin_o  out  N_IRQ  one-hot completion pulse to the served line.
- mie_i  in  N_IRQ  per-line enable from the mie CSR.
- irq_o  out  1  interrupt pending to the core.
- irq_cause_o  out  32  {1'b1, 31'(CAUSE_BASE + id)}; valid while irq_o = 1.
- irq_ack_i  in  1  core entered the trap handler for the presented interrupt.
- irq_ret_i  in  1  core executed mret.

Behaviour:
- Reset (rst_n_i low, async): state IDLE; pending, id and rr pointer cleared; irq_o = 0, irq_cause_o = 0, int_fin_o = 0. A reset during REQ, SERVICE or FIN aborts the service; no int_fin_o pulse is emitted.
- Pending register, updated every cycle:
  - Edge line: set on a 0->1 transition of int_req_i (previous-sample register). Cleared in the FIN cycle of that line. If a set and a clear occur in the same cycle, set wins.
  - Level line: pending[i] = registered int_req_i[i].
- Eligible lines = pending & mie_i.
- State IDLE:
  - If any line is eligible, latch id = winner (fixed priority, lowest index wins) and go to REQ.
  - irq_o rises the cycle after the eligible request is registered. Latency from int_req_i rise to irq_o is 2 clocks.
- State REQ:
  - irq_o = 1; id and cause are held stable even if the line drops or mie_i clears (the request is committed).
  - irq_ack_i -> SERVICE. irq_o falls the next cycle.
- State SERVICE:
  - irq_o = 0; waits for irq_ret_i -> FIN.
  - New requests only accumulate in pending; there is no nesting.
- State FIN:
  - int_fin_o[id] = 1 for exactly one cycle; edge pending[id] is cleared.
  - Next state GAP.
- State GAP:
  - One cycle; id is excluded from eligibility, which gives the source one clock to drop a level request.
  - Next state IDLE.
- Out-of-state handshakes: irq_ack_i outside REQ and irq_ret_i outside SERVICE are ignored. irq_ack_i and irq_ret_i both high in REQ: only ack is taken.
- Minimum spacing: 2 cycles between int_fin_o and the next irq_o rise.
- Width rule: id width is ID_W = max(1, $clog2(N_IRQ)), zero-extended into the cause field.

Optional Feature:
- Macro: MIRISCV_IRQ_RR_EN.
- Defined: round-robin arbitration. An rr pointer (ID_W bits, reset 0) is set to id+1 (wrapping modulo N_IRQ) in FIN, and the search starts at the pointer.
- Undefined: fixed priority, lowest index wins. The rr pointer logic is absent.

Decomposition:
- Package miriscv_irq_pkg: state enum (IDLE, REQ, SERVICE, FIN, GAP), IRQ_CAUSE_MSB constant, and a function computing mcause from id.
- One sub-module, miriscv_irq_arb: combinational find-first-set with start offset. Offset is tied to 0 when MIRISCV_IRQ_RR_EN is undefined.

Test Plan:
- Level request: line 5 high, mie=all, ack 3 cycles after irq_o, ret 10 cycles later -> irq_o 2 clocks after request, cause 0x8000_0015, int_fin_o = 0x20 for 1 cycle; bench drops request and no re-trigger occurs.
- Masked line: mie[5]=0, line 5 high -> no irq_o. Then set mie[5]=1 -> irq_o within 1 cycle.
- Simultaneous lines 3 and 7 -> line 3 served first, then line 7. With MIRISCV_IRQ_RR_EN and both held, services alternate 3, 7, 3.
- Edge line 2 (EDGE_MASK bit 2 = 1): pulse twice during SERVICE -> one extra service follows, not two. Pulse in the FIN cycle -> pending remains set.
- Committed request: during REQ, drop line 5 and clear mie[5] -> irq_o and cause held until ack.
- Reset in SERVICE -> all outputs 0 immediately, no int_fin_o. A line still high is served again after reset.

Source files
------------

// File: rtl/miriscv_irq_pkg.sv
// Shared types and helpers for the miriscv interrupt controller.
package miriscv_irq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        SERVICE,
        FIN,
        GAP
    } irq_state_e;

    localparam int unsigned IRQ_CAUSE_MSB = 31;

    // mcause for an external interrupt: interrupt flag on top, code below.
    function automatic logic [IRQ_CAUSE_MSB:0] irq_cause(input int unsigned base,
                                                         input int unsigned id);
        return {1'b1, 31'(base + id)};
    endfunction

endpackage

// File: rtl/miriscv_irq_arb.sv
// Find-first-set over the request vector, searching upward from a start offset with wrap.
module miriscv_irq_arb #(
    parameter int unsigned N_IRQ = 32,
    parameter int unsigned ID_W  = 5
) (
    input  logic [N_IRQ-1:0] req,
    input  logic [ID_W-1:0]  offset,
    output logic             any_c,
    output logic [ID_W-1:0]  id_c
);

    logic [2*N_IRQ-1:0] req_dbl;
    logic [N_IRQ-1:0]   req_rot;
    logic [N_IRQ-1:0]   scan;
    logic [ID_W:0]      pos;

    assign req_dbl = {req, req};
    assign req_rot = N_IRQ'(req_dbl >> offset);

    // Position found in the rotated view is mapped back by adding the offset modulo N_IRQ.
    always_comb begin
        any_c = 1'b0;
        pos   = '0;
        scan  = '0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            scan = req_rot >> i;
            if (!any_c && scan[0]) begin
                any_c = 1'b1;
                pos   = {1'b0, offset} + (ID_W+1)'(i);
            end
        end
        if (pos >= (ID_W+1)'(N_IRQ)) begin
            id_c = ID_W'(pos - (ID_W+1)'(N_IRQ));
        end else begin
            id_c = ID_W'(pos);
        end
    end

endmodule

// File: rtl/miriscv_irq_ctrl.sv
// Interrupt controller: latch/mask/arbitrate request lines, hand one to the core, signal completion.
// Define MIRISCV_IRQ_RR_EN for round-robin arbitration; default is fixed priority (lowest index).
module miriscv_irq_ctrl
    import miriscv_irq_pkg::*;
#(
    parameter int unsigned      N_IRQ      = 32,
    parameter logic [N_IRQ-1:0] EDGE_MASK  = '0,
    parameter int unsigned      CAUSE_BASE = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [N_IRQ-1:0] int_req_i,
    output logic [N_IRQ-1:0] int_fin_o,
    input  logic [N_IRQ-1:0] mie_i,
    output logic             irq_o,
    output logic [31:0]      irq_cause_o,
    input  logic             irq_ack_i,
    input  logic             irq_ret_i
);

    localparam int unsigned ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    irq_state_e       state_q, state_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [N_IRQ-1:0] req_q;
    logic [N_IRQ-1:0] edge_pend_q;
    logic             rearm_q;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] fin_mask;
    logic [N_IRQ-1:0] edge_clr;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] eligible;
    logic             arb_any;
    logic [ID_W-1:0]  arb_id;
    logic [ID_W-1:0]  arb_offset;
    logic             irq_d;
    logic [31:0]      cause_d;
    logic [N_IRQ-1:0] fin_d;

    assign rise     = int_req_i & ~req_q & EDGE_MASK;
    assign fin_mask = N_IRQ'(1'b1) << id_q;
    assign edge_clr = (state_q == FIN && !rearm_q) ? fin_mask : '0;
    assign pending  = (edge_pend_q & EDGE_MASK) | (req_q & ~EDGE_MASK);
    assign eligible = pending & mie_i;

    // Request sampling and edge capture; a new edge always beats the FIN clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            req_q       <= '0;
            edge_pend_q <= '0;
        end else begin
            req_q       <= int_req_i;
            edge_pend_q <= (edge_pend_q & ~edge_clr) | rise;
        end
    end

    // An edge on the served line after trap entry is a new event and must survive the FIN clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rearm_q <= 1'b0;
        end else if (state_q == IDLE) begin
            rearm_q <= 1'b0;
        end else if (state_q == SERVICE && |(rise & fin_mask)) begin
            rearm_q <= 1'b1;
        end
    end

`ifdef MIRISCV_IRQ_RR_EN
    logic [ID_W-1:0] rr_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rr_q <= '0;
        end else if (state_q == FIN) begin
            rr_q <= (id_q == ID_W'(N_IRQ - 1)) ? '0 : id_q + ID_W'(1);
        end
    end

    assign arb_offset = rr_q;
`else
    assign arb_offset = '0;
`endif

    miriscv_irq_arb #(
        .N_IRQ (N_IRQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req    (eligible),
        .offset (arb_offset),
        .any_c  (arb_any),
        .id_c   (arb_id)
    );

    // State, id and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            id_q        <= '0;
            irq_o       <= 1'b0;
            irq_cause_o <= '0;
            int_fin_o   <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            irq_o       <= irq_d;
            irq_cause_o <= cause_d;
            int_fin_o   <= fin_d;
        end
    end

    // Next state; id is committed on leaving IDLE and held until the next arbitration.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d = REQ;
                    id_d    = arb_id;
                end
            end
            REQ:     if (irq_ack_i) state_d = SERVICE;
            SERVICE: if (irq_ret_i) state_d = FIN;
            FIN:     state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output values for the coming state.
    always_comb begin
        irq_d   = (state_d == REQ);
        cause_d = '0;
        fin_d   = '0;
        if (state_d == REQ) begin
            cause_d = irq_cause(CAUSE_BASE, 32'(id_d));
        end
        if (state_d == FIN) begin
            fin_d = fin_mask;
        end
    end

endmodule

// File: tb/tb_miriscv_irq_ctrl.sv
// Scoreboard bench for miriscv_irq_ctrl: stimulus predicts irq/fin events, a monitor checks them.
module tb_miriscv_irq_ctrl;

    localparam int unsigned N    = 32;
    localparam logic [31:0] EDGE = 32'h0000_0004;
    localparam int unsigned BASE = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] int_req;
    logic [31:0] int_fin;
    logic [31:0] mie;
    logic        irq;
    logic [31:0] cause;
    logic        ack;
    logic        ret;

    always #5 clk = ~clk;

    miriscv_irq_ctrl #(
        .N_IRQ      (N),
        .EDGE_MASK  (EDGE),
        .CAUSE_BASE (BASE)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .int_req_i   (int_req),
        .int_fin_o   (int_fin),
        .mie_i       (mie),
        .irq_o       (irq),
        .irq_cause_o (cause),
        .irq_ack_i   (ack),
        .irq_ret_i   (ret)
    );

    typedef struct {
        bit          is_fin;
        logic [31:0] val;
        int          at;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   rr_m   = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop(input bit is_fin, input logic [31:0] v);
        exp_t e;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: got %h at cyc %0d expected no event", is_fin ? "fin" : "irq", v, cyc);
            return;
        end
        e = expq.pop_front();
        if (e.is_fin != is_fin || e.val !== v || (e.at >= 0 && e.at != cyc)) begin
            errors++;
            $display("FAIL event: got fin=%0d val=%h cyc=%0d expected fin=%0d val=%h cyc=%0d",
                     is_fin, v, cyc, e.is_fin, e.val, e.at);
        end
    endtask

    // Monitor: outputs only move on posedge (or async reset), so sample on negedge.
    logic        irq_prev   = 1'b0;
    logic [31:0] cause_prev = '0;
    logic [31:0] fin_prev   = '0;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (irq && !irq_prev) pop(1'b0, cause);
            if (irq && irq_prev) check("cause_hold", cause, cause_prev);
            if (fin_prev != 0) check("fin_one_cycle", int_fin, 32'h0);
            if (int_fin != 0) pop(1'b1, int_fin);
        end
        irq_prev   = irq;
        cause_prev = cause;
        fin_prev   = int_fin;
    end

    // Reference arbitration: first eligible line at or after the rr pointer.
    task automatic model_pick(input logic [31:0] rem, output int idx);
        idx = -1;
        for (int k = 0; k < 32; k++) begin
            int j;
            j = (rr_m + k) % 32;
            if (idx < 0 && ((rem >> j) & 32'h1) != 0) idx = j;
        end
`ifdef MIRISCV_IRQ_RR_EN
        if (idx >= 0) rr_m = (idx + 1) % 32;
`endif
    endtask

    task automatic push_irq(input int line, input int at);
        exp_t e;
        e.is_fin = 1'b0;
        e.val    = 32'h8000_0000 | 32'(BASE + line);
        e.at     = at;
        expq.push_back(e);
    endtask

    task automatic push_fin(input int line);
        exp_t e;
        e.is_fin = 1'b1;
        e.val    = 32'h1 << line;
        e.at     = -1;
        expq.push_back(e);
    endtask

    // Predict the service order of a set of held level lines that drop once served.
    task automatic predict(input logic [31:0] rem_in);
        logic [31:0] rem;
        int idx;
        rem = rem_in;
        while (rem != 0) begin
            model_pick(rem, idx);
            push_irq(idx, -1);
            push_fin(idx);
            rem = rem & ~(32'h1 << idx);
        end
    endtask

    task automatic wait_irq(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (irq) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL irq_timeout: got irq_o=0 expected 1 at cyc %0d", cyc);
        end
    endtask

    task automatic pulse2;
        int_req[2] = 1'b1;
        @(negedge clk);
        int_req[2] = 1'b0;
    endtask

    // pmode 1: two edge pulses on line 2 during SERVICE; pmode 2: one pulse in the FIN cycle.
    task automatic serve(input int ack_dly, input int ret_dly, input bit drop, input int pmode);
        bit ok;
        wait_irq(ok);
        if (!ok) return;
        repeat (ack_dly) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("irq_fall", {31'b0, irq}, 32'h0);
        if (pmode == 1) begin
            pulse2();
            @(negedge clk);
            pulse2();
            @(negedge clk);
        end
        repeat (ret_dly) @(negedge clk);
        ret = 1'b1;
        @(negedge clk);
        ret = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (int_fin != 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL fin_timeout: got int_fin_o=0 expected pulse at cyc %0d", cyc);
            return;
        end
        if (drop) int_req = int_req & ~int_fin;
        if (pmode == 2) pulse2();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected finish before 500000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int          idx;
        logic [31:0] s;
        logic [31:0] m;

        rst_n   = 1'b0;
        int_req = '0;
        mie     = '1;
        ack     = 1'b0;
        ret     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_cause", cause, 32'h0);
        check("rst_fin", int_fin, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Level line 5: irq two clocks after the request, no re-trigger after drop.
        model_pick(32'h20, idx);
        push_irq(idx, cyc + 2);
        push_fin(idx);
        int_req[5] = 1'b1;
        serve(3, 10, 1'b1, 0);
        repeat (12) @(negedge clk);
        check("no_retrigger", {31'b0, irq}, 32'h0);

        // Masked line, then enabled: irq one clock after mie rises.
        mie[5]     = 1'b0;
        int_req[5] = 1'b1;
        repeat (8) @(negedge clk);
        check("masked_no_irq", {31'b0, irq}, 32'h0);
        model_pick(32'h20, idx);
        push_irq(idx, cyc + 1);
        push_fin(idx);
        mie = '1;
        serve(0, 2, 1'b1, 0);
        repeat (4) @(negedge clk);

        // Lines 3 and 7 together, each dropped once served.
        predict(32'h88);
        int_req = int_req | 32'h88;
        serve(1, 1, 1'b1, 0);
        serve(2, 0, 1'b1, 0);
        repeat (4) @(negedge clk);

        // Lines 3 and 7 held through three services.
        for (int k = 0; k < 3; k++) begin
            model_pick(32'h88, idx);
            push_irq(idx, -1);
            push_fin(idx);
        end
        int_req = int_req | 32'h88;
        for (int k = 0; k < 3; k++) serve(0, 1, 1'b0, 0);
        int_req = int_req & ~32'h88;
        repeat (6) @(negedge clk);

        // Edge line 2: two pulses in SERVICE give one extra service; a FIN-cycle pulse stays pending.
        push_irq(2, -1);
        push_fin(2);
        push_irq(2, -1);
        push_fin(2);
        pulse2();
        serve(1, 1, 1'b0, 1);
        serve(1, 1, 1'b0, 0);
        repeat (10) @(negedge clk);
        push_irq(2, -1);
        push_fin(2);
        push_irq(2, -1);
        push_fin(2);
        pulse2();
        serve(0, 1, 1'b0, 2);
        serve(0, 0, 1'b0, 0);
        repeat (10) @(negedge clk);

        // Committed request: id and cause held after the line drops and is masked.
        model_pick(32'h20, idx);
        push_irq(idx, -1);
        push_fin(idx);
        int_req[5] = 1'b1;
        wait_irq(ok);
        int_req[5] = 1'b0;
        mie[5]     = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("commit_irq", {31'b0, irq}, 32'h1);
            check("commit_cause", cause, 32'h8000_0015);
        end
        serve(1, 2, 1'b0, 0);
        repeat (3) @(negedge clk);
        mie = '1;
        repeat (3) @(negedge clk);

        // Reset while presenting, then while in service; the held line is served afresh.
        model_pick(32'h20, idx);
        push_irq(idx, -1);
        int_req[5] = 1'b1;
        wait_irq(ok);
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_irq", {31'b0, irq}, 32'h0);
        check("rst_req_cause", cause, 32'h0);
        rr_m = 0;
        model_pick(32'h20, idx);
        push_irq(idx, -1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_irq(ok);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_svc_irq", {31'b0, irq}, 32'h0);
        check("rst_svc_fin", int_fin, 32'h0);
        check("rst_svc_cause", cause, 32'h0);
        rr_m = 0;
        model_pick(32'h20, idx);
        push_irq(idx, -1);
        push_fin(idx);
        @(negedge clk);
        #2 rst_n = 1'b1;
        serve(0, 1, 1'b1, 0);
        repeat (4) @(negedge clk);

        // Random held level sets under random masks.
        for (int r = 0; r < 15; r++) begin
            s = $urandom & $urandom & $urandom & ~EDGE;
            if (s == 0) s = 32'h1 << $urandom_range(3, 31);
            m = ~($urandom & $urandom);
            mie = m;
            predict(s & m);
            int_req = s;
            for (int k = 0; k < $countones(s & m); k++)
                serve($urandom_range(0, 3), $urandom_range(0, 4), 1'b1, 0);
            int_req = '0;
            repeat (3) @(negedge clk);
            mie = '1;
            repeat (2) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        check("queue_empty", 32'(expq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
